// File: rtl/game_input_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_input_ctrl_if
// Control link between the input conditioner and the game FSM.
//   state       FSM -> conditioner   current game state (0 INITIAL, 1 PLAYING,
//                                     2 OVER, 3 unused)
//   start_game  conditioner -> FSM   1-cycle pulse: begin game
//   restart     conditioner -> FSM   1-cycle pulse: return to INITIAL
//   flap        conditioner -> FSM   1-cycle pulse: bird flap
// The master modport is the conditioner; the slave modport is the FSM.
// -----------------------------------------------------------------------------
interface game_input_ctrl_if;
    logic [1:0] state;
    logic       start_game;
    logic       restart;
    logic       flap;

    modport master (
        input  state,
        output start_game,
        output restart,
        output flap
    );

    modport slave (
        output state,
        input  start_game,
        input  restart,
        input  flap
    );
endinterface

// File: rtl/game_input_ctrl.sv
// -----------------------------------------------------------------------------
// game_input_ctrl
// Conditions the raw FLAP and RESTART buttons (2-FF synchroniser, debounce,
// rising-edge detect). It turns them into one-cycle command pulses for the game
// FSM. Commands are gated by the FSM's fed-back state, so only legal commands
// reach it.
// Ports:
//   clk          system clock, single domain
//   rst_n        synchronous reset, active-low
//   btn_flap     raw FLAP button, asynchronous, active-high
//   btn_restart  raw RESTART button, asynchronous, active-high
//   ctrl         game_input_ctrl_if.master (state in; start_game/restart/flap out)
// Latency: a raw press held stable produces its pulse DEBOUNCE_CYCLES+3 clock
// edges after the first edge that samples it high.
// -----------------------------------------------------------------------------
module game_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_flap,
    input  logic               btn_restart,
    game_input_ctrl_if.master  ctrl
);

    typedef enum logic [1:0] {
        ST_INITIAL = 2'd0,
        ST_PLAYING = 2'd1,
        ST_OVER    = 2'd2,
        ST_UNUSED  = 2'd3
    } game_state_e;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DB_ZERO   = {DW{1'b0}};
    localparam logic [DW-1:0] DB_ONE    = DW'(1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    // Bit 0 carries FLAP, bit 1 carries RESTART throughout the pipeline.
    localparam int B_FLAP    = 0;
    localparam int B_RESTART = 1;

    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    db_r;
    logic [1:0]    db_d_r;
    logic [1:0]    rise_r;
    logic [DW-1:0] db_cnt_r [2];
    logic [HW-1:0] hold_cnt_r;
    logic [HW-1:0] hold_cnt_nxt_s;

    game_state_e   state_s;
    logic          hold_fire_s;
    logic          start_c_s;
    logic          restart_c_s;
    logic          flap_c_s;

    logic          start_game_r;
    logic          restart_r;
    logic          flap_r;

    assign raw_s   = {btn_restart, btn_flap};
    assign state_s = game_state_e'(ctrl.state);

    // Synchroniser, debounce counters, delayed level and registered press edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            db_r    <= 2'b00;
            db_d_r  <= 2'b00;
            rise_r  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= DB_ZERO;
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            db_d_r  <= db_r;
            rise_r  <= db_r & ~db_d_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    db_cnt_r[i] <= DB_ZERO;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                    db_r[i]     <= sync2_r[i];
                    db_cnt_r[i] <= DB_ZERO;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                end
            end
        end
    end

    // Restart hold counter: counts while held in PLAYING, saturates so one hold
    // gives exactly one pulse.
    always_comb begin
        hold_cnt_nxt_s = hold_cnt_r;
        hold_fire_s    = 1'b0;
        if ((state_s != ST_PLAYING) || !db_r[B_RESTART]) begin
            hold_cnt_nxt_s = HOLD_ZERO;
        end else if (hold_cnt_r != HOLD_MAX) begin
            hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
            hold_fire_s    = (hold_cnt_r == HOLD_LAST);
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end
    end

    // Command decode from press edges and current game state; restart beats start.
    always_comb begin
        start_c_s   = 1'b0;
        restart_c_s = 1'b0;
        flap_c_s    = 1'b0;
        case (state_s)
            ST_INITIAL: begin
                restart_c_s = rise_r[B_RESTART];
                start_c_s   = rise_r[B_FLAP] & ~rise_r[B_RESTART];
            end
            ST_PLAYING: begin
                flap_c_s    = rise_r[B_FLAP];
                restart_c_s = hold_fire_s;
            end
            ST_OVER: begin
                restart_c_s = rise_r[B_RESTART];
            end
            ST_UNUSED: begin
                restart_c_s = 1'b0;
            end
            default: begin
                restart_c_s = 1'b0;
            end
        endcase
    end

    // Registered command pulses and hold counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_r   <= HOLD_ZERO;
            start_game_r <= 1'b0;
            restart_r    <= 1'b0;
            flap_r       <= 1'b0;
        end else begin
            hold_cnt_r   <= hold_cnt_nxt_s;
            start_game_r <= start_c_s;
            restart_r    <= restart_c_s;
            flap_r       <= flap_c_s;
        end
    end

    assign ctrl.start_game = start_game_r;
    assign ctrl.restart    = restart_r;
    assign ctrl.flap       = flap_r;

endmodule

// File: tb/tb_game_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_input_ctrl
// Directed stimulus for game_input_ctrl with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
// Each stimulus pushes the pulse it expects (kind plus the cycle count at which
// the pulse must be visible) into a queue. A monitor pops an entry and compares
// whenever any output pulses.
// -----------------------------------------------------------------------------
module tb_game_input_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int LAT  = DEB + 4;   // drive point to visible pulse, in cycle counts

    localparam int K_START   = 0;
    localparam int K_RESTART = 1;
    localparam int K_FLAP    = 2;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic btn_flap;
    logic btn_restart;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q [$];

    game_input_ctrl_if ctrl_if ();

    game_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_flap    (btn_flap),
        .btn_restart (btn_restart),
        .ctrl        (ctrl_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used as the time base for expected pulses.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_START:   return "start_game";
            K_RESTART: return "restart";
            K_FLAP:    return "flap";
            default:   return "none";
        endcase
    endfunction

    task automatic expect_pulse(input int kind, input int at_cyc);
        exp_t e;
        e.kind = kind;
        e.cyc  = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic check_pulse(input int kind);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: got %s at cycle %0d, required no pulse",
                     kname(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                failures++;
                $display("FAIL pulse_kind: got %s at cycle %0d, required %s",
                         kname(kind), cyc, kname(e.kind));
            end
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL pulse_cycle: %s at cycle %0d, required cycle %0d",
                         kname(kind), cyc, e.cyc);
            end
        end
    endtask

    // Monitor: sample outputs on the falling edge and compare with the queue.
    always @(negedge clk) begin
        if (ctrl_if.start_game === 1'b1) check_pulse(K_START);
        if (ctrl_if.restart    === 1'b1) check_pulse(K_RESTART);
        if (ctrl_if.flap       === 1'b1) check_pulse(K_FLAP);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        logic [2:0] got;
        got = {ctrl_if.flap, ctrl_if.restart, ctrl_if.start_game};
        checks++;
        if (got !== 3'b000) begin
            failures++;
            $display("FAIL %s: outputs {flap,restart,start}=%b, required 000", name, got);
        end
    endtask

    // Press a button at a falling edge and hold it for n cycles, then release.
    task automatic press(input bit f, input bit r, input int n);
        btn_flap    = f;
        btn_restart = r;
        idle(n);
        btn_flap    = 1'b0;
        btn_restart = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        btn_flap    = 1'b0;
        btn_restart = 1'b0;
        ctrl_if.state = 2'd0;

        // Reset state.
        idle(3);
        check_quiet("reset_outputs");
        rst_n = 1'b1;
        idle(10);
        check_quiet("post_reset_idle");

        // 1: INITIAL, flap held 20 cycles -> one start_game.
        ctrl_if.state = 2'd0;
        expect_pulse(K_START, cyc + LAT);
        press(1'b1, 1'b0, 20);
        idle(20);
        check_drained("t1_start_game");

        // 2: PLAYING, 3-cycle glitch ignored; 10-cycle press -> one flap.
        ctrl_if.state = 2'd1;
        press(1'b1, 1'b0, 3);
        idle(10);
        check_drained("t2_glitch");
        expect_pulse(K_FLAP, cyc + LAT);
        press(1'b1, 1'b0, 10);
        idle(20);
        check_drained("t2_flap");

        // 3: PLAYING, restart held 30 -> pulse HOLD cycles after db rise.
        expect_pulse(K_RESTART, cyc + DEB + 2 + HOLD);
        press(1'b0, 1'b1, 30);
        idle(20);
        check_drained("t3_hold_restart");
        press(1'b0, 1'b1, 6);
        idle(20);
        check_drained("t3_short_hold");

        // 4: OVER, restart press immediate; flap ignored.
        ctrl_if.state = 2'd2;
        expect_pulse(K_RESTART, cyc + LAT);
        press(1'b0, 1'b1, 10);
        idle(20);
        check_drained("t4_over_restart");
        press(1'b1, 1'b0, 10);
        idle(20);
        check_drained("t4_over_flap");

        // 5: INITIAL, both rise together -> restart only.
        ctrl_if.state = 2'd0;
        expect_pulse(K_RESTART, cyc + LAT);
        press(1'b1, 1'b1, 10);
        idle(20);
        check_drained("t5_simultaneous");

        // State 3: no pulses from either button.
        ctrl_if.state = 2'd3;
        press(1'b1, 1'b1, 10);
        idle(20);
        check_drained("t_state3");

        // 6: flap held through a reset mid-debounce.
        ctrl_if.state = 2'd0;
        btn_flap = 1'b1;
        idle(2);
        rst_n = 1'b0;
        repeat (5) begin
            idle(1);
            check_quiet("t6_in_reset");
        end
        rst_n = 1'b1;
        expect_pulse(K_START, cyc + LAT);
        idle(20);
        btn_flap = 1'b0;
        idle(20);
        check_drained("t6_reset_rearm");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
